stream_arb: RTL and testbench

STREAM_ARB -- requirements
Module: stream_arb

---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_arb_rr_pick.sv | 29 ++
 rtl/stream_arb.sv | 126 ++++++++++++
 tb/tb_stream_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and defaults for the stream arbiter slice.
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_BEATS_DEF = 16;

endpackage

// File: rtl/stream_arb_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb.sv
// Packet-granular round-robin stream arbiter with registered output stage
// and forced termination of over-long packets.
module stream_arb
    import stream_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic [7:0]                pkt_count,
    output logic                      err_trunc
);

    localparam int unsigned PW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     beat_cnt;

    logic [NUM_SRC-1:0] pick_grant;
    logic               pick_any;
    logic [PW-1:0]      gidx;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic               out_free;
    logic               accept;
    logic               max_hit;
    logic               release_pkt;

    rr_pick #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_pick (
        .req   (s_tvalid),
        .ptr   (ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Decode the registered one-hot owner into an index and its lane.
    always_comb begin
        gidx     = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                gidx     = gidx | PW'(i);
                sel_data = sel_data | s_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_last    = |(s_tlast & grant);
    assign out_free    = !m_tvalid || m_tready;
    assign s_tready    = busy ? (grant & {NUM_SRC{out_free}}) : '0;
    assign accept      = |(s_tvalid & s_tready);
    assign max_hit     = (beat_cnt == CW'(MAX_BEATS - 1));
    assign release_pkt = accept && (sel_last || max_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant     <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            pkt_count <= '0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= 1'b0;

            if (accept) begin
                m_tdata  <= sel_data;
                m_tvalid <= 1'b1;
                m_tlast  <= sel_last || max_hit;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_grant;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (release_pkt) begin
                        ptr       <= (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
                        pkt_count <= pkt_count + 8'd1;
                        err_trunc <= !sel_last;
                        grant     <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arb.sv
// Directed self-checking bench for stream_arb with hand-computed expectations.
module tb_stream_arb;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DATA_W  = 8;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tready;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tvalid;
    logic                      m_tlast;
    logic                      m_tready;
    logic [NUM_SRC-1:0]        grant;
    logic                      busy;
    logic [7:0]                pkt_count;
    logic                      err_trunc;

    int unsigned total;
    int unsigned bad;

    stream_arb #(
        .NUM_SRC   (NUM_SRC),
        .DATA_W    (DATA_W),
        .MAX_BEATS (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant     (grant),
        .busy      (busy),
        .pkt_count (pkt_count),
        .err_trunc (err_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned i, input logic v, input logic [7:0] d, input logic l);
        s_tvalid[i]                = v;
        s_tdata[i*DATA_W +: DATA_W] = d;
        s_tlast[i]                 = l;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [3:0] exp_g [0:8];

    initial begin
        total = 0;
        bad   = 0;

        // reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mvalid", 32'(m_tvalid), 32'h0);
        check("rst_mdata", 32'(m_tdata), 32'h0);
        check("rst_pkt", 32'(pkt_count), 32'h0);
        check("rst_err", 32'(err_trunc), 32'h0);

        // single source 1, three beats
        set_src(1, 1'b1, 8'hA1, 1'b0);
        tick();
        check("s1_grant", 32'(grant), 32'h2);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_ready", 32'(s_tready), 32'h2);
        tick();
        check("s1_d1", 32'(m_tdata), 32'hA1);
        check("s1_l1", 32'(m_tlast), 32'h0);
        set_src(1, 1'b1, 8'hA2, 1'b0);
        tick();
        check("s1_d2", 32'(m_tdata), 32'hA2);
        set_src(1, 1'b1, 8'hA3, 1'b1);
        tick();
        check("s1_d3", 32'(m_tdata), 32'hA3);
        check("s1_l3", 32'(m_tlast), 32'h1);
        check("s1_v3", 32'(m_tvalid), 32'h1);
        check("s1_pkt", 32'(pkt_count), 32'h1);
        check("s1_rel", 32'(grant), 32'h0);
        set_src(1, 1'b0, 8'h00, 1'b0);
        tick();
        check("s1_drain", 32'(m_tvalid), 32'h0);

        // all four sources, one-beat packets: grant 0,1,2,3,0 with idle gaps
        do_reset();
        exp_g[0] = 4'h1; exp_g[1] = 4'h0; exp_g[2] = 4'h2; exp_g[3] = 4'h0;
        exp_g[4] = 4'h4; exp_g[5] = 4'h0; exp_g[6] = 4'h8; exp_g[7] = 4'h0;
        exp_g[8] = 4'h1;
        for (int unsigned i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 8'(8'h30 + i), 1'b1);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), 32'(grant), 32'(exp_g[k]));
            check($sformatf("rr_ready%0d", k), 32'(s_tready), 32'(exp_g[k]));
            if (k % 2 == 1) check($sformatf("rr_data%0d", k), 32'(m_tdata), 32'(8'h30 + k / 2));
        end
        check("rr_pkt", 32'(pkt_count), 32'h4);

        // backpressure on source 0
        do_reset();
        set_src(0, 1'b1, 8'h10, 1'b0);
        tick();
        check("bp_grant", 32'(grant), 32'h1);
        tick();
        m_tready = 1'b0;
        set_src(0, 1'b1, 8'h11, 1'b1);
        check("bp_d0", 32'(m_tdata), 32'h10);
        check("bp_l0", 32'(m_tlast), 32'h0);
        check("bp_rdy0", 32'(s_tready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold%0d", k), 32'(m_tdata), 32'h10);
            check($sformatf("bp_vld%0d", k), 32'(m_tvalid), 32'h1);
            check($sformatf("bp_rdy%0d", k), 32'(s_tready), 32'h0);
        end
        m_tready = 1'b1;
        #1;
        check("bp_rdy_on", 32'(s_tready), 32'h1);
        tick();
        check("bp_d1", 32'(m_tdata), 32'h11);
        check("bp_l1", 32'(m_tlast), 32'h1);
        check("bp_pkt", 32'(pkt_count), 32'h1);
        set_src(0, 1'b0, 8'h00, 1'b0);
        tick();
        check("bp_drain", 32'(m_tvalid), 32'h0);
        check("bp_pkt2", 32'(pkt_count), 32'h1);

        // source 2 overruns the beat limit
        do_reset();
        set_src(2, 1'b1, 8'h00, 1'b0);
        tick();
        check("tr_grant", 32'(grant), 32'h4);
        for (int b = 1; b <= 16; b++) begin
            set_src(2, 1'b1, 8'(b), 1'b0);
            tick();
            check($sformatf("tr_d%0d", b), 32'(m_tdata), 32'(b));
            check($sformatf("tr_l%0d", b), 32'(m_tlast), 32'(b == 16));
            check($sformatf("tr_e%0d", b), 32'(err_trunc), 32'(b == 16));
        end
        check("tr_pkt", 32'(pkt_count), 32'h1);
        check("tr_rel", 32'(grant), 32'h0);
        set_src(2, 1'b1, 8'd17, 1'b0);
        tick();
        check("tr_regrant", 32'(grant), 32'h4);
        check("tr_err_off", 32'(err_trunc), 32'h0);
        check("tr_idle_v", 32'(m_tvalid), 32'h0);
        tick();
        check("tr_d17", 32'(m_tdata), 32'd17);
        check("tr_l17", 32'(m_tlast), 32'h0);
        check("tr_pkt2", 32'(pkt_count), 32'h1);

        // reset mid-packet from source 3
        do_reset();
        set_src(3, 1'b1, 8'h50, 1'b0);
        tick();
        check("mr_grant", 32'(grant), 32'h8);
        set_src(3, 1'b1, 8'h51, 1'b0);
        tick();
        set_src(3, 1'b1, 8'h52, 1'b0);
        tick();
        check("mr_d2", 32'(m_tdata), 32'h52);
        rst = 1'b1;
        set_src(3, 1'b1, 8'h53, 1'b0);
        tick();
        check("mr_grant0", 32'(grant), 32'h0);
        check("mr_busy0", 32'(busy), 32'h0);
        check("mr_data0", 32'(m_tdata), 32'h0);
        check("mr_vld0", 32'(m_tvalid), 32'h0);
        check("mr_last0", 32'(m_tlast), 32'h0);
        check("mr_pkt0", 32'(pkt_count), 32'h0);
        rst = 1'b0;
        set_src(0, 1'b1, 8'h60, 1'b1);
        tick();
        check("mr_ptr_grant", 32'(grant), 32'h1);
        check("mr_no_last", 32'(m_tlast), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
